// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial byte receiver: FSM state encoding, default
// frame shape and the parity-check rule.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam bit          DEF_PARITY_EN  = 1'b1;
    localparam bit          DEF_PARITY_ODD = 1'b0;

    // data_xor is the reduction XOR of the received data bits.
    function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                        input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// Right-shift register that fills LSB-first: each enabled bit enters at the MSB
// and the oldest bit ends up in bit 0.
module bit_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              din_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= {din_i, q_q[DATA_W-1:1]};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional parity,
// stop bit. Presents the word with one-cycle valid/error pulses; all outputs registered.
module serial_byte_receiver
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter bit          PARITY_EN  = DEF_PARITY_EN,
    parameter bit          PARITY_ODD = DEF_PARITY_ODD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_bit_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              busy_q;

    logic [DATA_W-1:0] shreg;
    logic              shift_en;

    assign shift_en = bit_en && (state_q == S_DATA);

    bit_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shreg (
        .clk_i(clk),
        .clr_i(rst),
        .en_i (shift_en),
        .din_i(din),
        .q_o  (shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            par_bit_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (!din) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        // Counter parks at its last value so it never exceeds DATA_W-1.
                        if (cnt_q == CNT_LAST) begin
                            state_q <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        par_bit_q <= din;
                        state_q   <= S_STOP;
                    end
                    S_STOP: begin
                        // A bad stop bit is consumed here and never restarts a frame.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (din) begin
                            data_q       <= shreg;
                            valid_q      <= 1'b1;
                            parity_err_q <= PARITY_EN &&
                                            parity_bad(^shreg, par_bit_q, PARITY_ODD);
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver (8 data bits, even parity): the driver
// pushes the expected frame result, a negedge monitor pops and compares.
module tb_serial_byte_receiver;

    localparam bit PODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       bit_en;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    serial_byte_receiver #(
        .DATA_W    (8),
        .PARITY_EN (1'b1),
        .PARITY_ODD(PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        bit         pe;
        bit         fe;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus; optionally checks busy as left by the previous edge.
    task automatic drive_cycle(input bit en, input bit d, input bit chk, input bit exp_busy);
        @(negedge clk);
        if (chk) check("busy", 32'(busy), 32'(exp_busy));
        bit_en = en;
        din    = d;
    endtask

    // Frame = start 0, data LSB-first, parity bit, stop bit; gap idle cycles between strobes.
    task automatic send_frame(input logic [7:0] data, input bit par, input bit stop,
                              input int gap, input bit chk_busy);
        bit   bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        bits.push_back(par);
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) drive_cycle(1'b0, 1'($urandom), chk_busy, 1'b1);
            end
            drive_cycle(1'b1, bits[i], chk_busy && (i > 0), 1'b1);
        end
        e.v   = stop;
        e.fe  = !stop;
        e.pe  = stop && ((($countones(data) + int'(par)) % 2) != int'(PODD));
        e.d   = stop ? data : last_good;
        e.cyc = cyc + 1;
        if (stop) last_good = data;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: valid=%b parity_err=%b frame_err=%b, required none",
                         valid, parity_err, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid", 32'(valid), 32'(mon_e.v));
                check("parity_err", 32'(parity_err), 32'(mon_e.pe));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("data_out", 32'(data_out), 32'(mon_e.d));
                check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_output: no pulse observed, required pulse by cycle %0d",
                     mon_e.cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        din    = 1'b0;

        // Reset held two cycles with din toggling.
        repeat (2) begin
            @(negedge clk);
            din    = ~din;
            bit_en = 1'b1;
        end
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst    = 1'b0;
        bit_en = 1'b0;
        din    = 1'b1;

        repeat (2) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b1, 3, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame after 4 data bits, asserted alongside a bit_en with din=0.
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'($urandom), 1'b1, 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        bit_en    = 1'b1;
        din       = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_data_out", 32'(data_out), 32'h0);
        rst    = 1'b0;
        bit_en = 1'b0;
        din    = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, 0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);

        // Randomised frames, back-to-back or with idle strobes between them.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         par;
            bit         stop;
            d    = 8'($urandom);
            par  = ($urandom_range(0, 4) == 0) ? !(^d) : ^d;
            stop = ($urandom_range(0, 6) != 0);
            send_frame(d, par, stop, int'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                drive_cycle(1'($urandom), 1'b1, 1'b1, 1'b0);
            end
        end

        repeat (5) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Serial-to-parallel frame receiver that consumes the registered 1-bit stream produced by the D flip-flop stage (SR-based D flip-flop, Q output). It hunts for a start bit, shifts in DATA_W data bits LSB-first, optionally checks a parity bit, and validates a stop bit. It then presents the word with a one-cycle valid pulse and error flags.

## Interface
- DATA_W, 8, data bits per frame; legal range ≥ 2.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.
- clk  input  1  single clock; everything is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial bit, driven by the upstream D flip-flop Q.
- bit_en  input  1  sample strobe; din is consumed only on edges where bit_en = 1.
- data_out  output  DATA_W  last good word; held until the next good frame.
- valid  output  1  one-cycle pulse when a frame completes with a correct stop bit.
- parity_err  output  1  one-cycle pulse coincident with valid when parity mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on bit_en with din = 0 (start bit), go to DATA and clear cnt. din = 1 is ignored.
  - DATA: on each bit_en, shift in LSB-first: shreg <= {din, shreg[DATA_W-1:1]}, cnt++. When cnt = DATA_W-1 is sampled, go to PARITY if PARITY_EN = 1, else STOP.
  - PARITY: on bit_en, capture din as par_bit and go to STOP.
  - STOP: on bit_en, return to IDLE.
    - din = 1: load data_out <= shreg and pulse valid. Pulse parity_err if PARITY_EN = 1 and (^shreg ^ par_bit) != PARITY_ODD.
    - din = 0: pulse frame_err only. valid and parity_err stay 0, and data_out is unchanged.
- The 0 sampled as a bad stop bit is never reused as a new start bit.
- bit_en = 0: state, cnt, shreg and par_bit hold, and din is ignored.
- cnt width is $clog2(DATA_W). cnt never exceeds DATA_W-1.
- Reset values: state IDLE, cnt 0, shreg 0, par_bit 0, data_out 0, valid 0, parity_err 0, frame_err 0, busy 0.
- Reset mid-frame: the partial frame is discarded, and the receiver is in IDLE on the edge after rst is sampled high.
- rst takes priority over bit_en on the same edge.

## Timing
- All outputs are registered. Nothing is combinational from din or bit_en to any output.
- With bit_en = 1 every cycle and the start bit sampled at edge 0:
  - data bits are sampled at edges 1 to DATA_W;
  - the parity bit, if enabled, is sampled at edge DATA_W+1;
  - the stop bit is sampled at edge DATA_W+2 with parity, or DATA_W+1 without.
- Outputs update on the same edge that samples the stop bit:
  - valid, parity_err and frame_err are high for exactly one cycle after that edge;
  - data_out changes on that edge.
- Back-to-back frames: a start bit may be sampled on the first bit_en edge after the stop edge. There is no dead cycle beyond that.
- busy rises after the start-bit edge and falls after the stop edge.

## Structure
- Shared package serial_rx_pkg holds the state encoding constants (S_IDLE, S_DATA, S_PARITY, S_STOP; 2-bit) and the default frame constants.
- One sub-module, bit_shift_reg:
  - parameterised DATA_W right-shift register with load-enable (bit_en and state == DATA) and synchronous clear;
  - the top-level holds the FSM, counter, parity and output registers.

## Test plan
1. Reset: hold rst = 1 for 2 cycles with din toggling -> data_out = 0, valid = parity_err = frame_err = busy = 0.
2. Continuous bit_en, frame start 0, data 0xA5 LSB-first, even parity bit 0, stop 1 -> valid pulses 1 cycle after edge 10, data_out = 8'hA5, parity_err = 0.
3. Same frame with parity bit 1 -> valid = 1 and parity_err = 1 in the same cycle, data_out = 8'hA5.
4. After a good 0xA5, send a frame with data 0x5A and stop bit 0 -> frame_err pulses 1 cycle, valid = 0, data_out stays 8'hA5, then IDLE.
5. bit_en high every 4th cycle, din randomised between strobes, frame 0x3C with correct parity -> valid once, data_out = 8'h3C, busy high throughout the frame.
6. rst pulse after 4 data bits of a frame -> busy = 0 next cycle. A following full frame 0x81 is received correctly: valid = 1, data_out = 8'h81, no error flags.
